// File: rtl/dma_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dma_write_arbiter: round-robin burst arbiter onto the 128-bit DMA    |
// | write port, with a registered write stage and a beat counter.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dma_write_arbiter #(
  parameter int NSRC      = 4,
  parameter int IDW       = 2,
  parameter int MAX_BURST = 256
) (
  input  logic                 cpu_clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NSRC-1:0]      src_valid,
  input  logic [NSRC-1:0]      src_last,
  input  logic [NSRC*128-1:0]  src_data,
  output logic [NSRC-1:0]      src_ready,
  output logic [127:0]         dma_in,
  output logic                 dma_we,
  input  logic                 dma_writable,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy,
  output logic [31:0]          beat_count
);

  localparam logic [0:0]     IDLE     = 1'b0;
  localparam logic [0:0]     BURST    = 1'b1;
  localparam logic [15:0]    LAST_CNT = 16'(MAX_BURST - 1);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NSRC - 1);
  localparam logic [IDW:0]   NSRC_W   = (IDW+1)'(NSRC);

  logic [0:0]     state;
  logic [0:0]     state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] pick;
  logic [IDW:0]   idx;
  logic           found;
  logic [15:0]    burst_cnt;
  logic           accept;
  logic           burst_end;

  // First valid source at or above rr_ptr, wrapping back to 0.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NSRC; k++) begin
      idx = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (idx >= NSRC_W) idx = idx - NSRC_W;
      if (!found && src_valid[idx[IDW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IDW-1:0];
      end
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      burst_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == BURST) begin
        grant_id  <= pick;
        burst_cnt <= '0;
      end
      if (burst_end) begin
        burst_cnt <= '0;
        rr_ptr    <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
      end else if (accept) begin
        burst_cnt <= burst_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable && found) state_nxt = BURST;
      BURST:   if (burst_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is suppressed during reset so nothing is handed over at the reset edge.
  always_comb begin
    src_ready = '0;
    if (state == BURST && !reset) src_ready[grant_id] = dma_writable;
    busy      = (state == BURST);
    accept    = src_valid[grant_id] & src_ready[grant_id];
    burst_end = accept & (src_last[grant_id] | (burst_cnt == LAST_CNT));
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      dma_we     <= 1'b0;
      dma_in     <= '0;
      beat_count <= '0;
    end else begin
      dma_we <= accept;
      if (accept) begin
        dma_in     <= src_data[{grant_id, 7'b0} +: 128];
        beat_count <= beat_count + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_write_arbiter.sv
`default_nettype none
// Randomized bench for dma_write_arbiter: a behavioural model and scoreboard
// checked every cycle, plus directed scenarios pinned with literal expectations.
module tb_dma_write_arbiter;
  localparam int NSRC = 4;
  localparam int IDW  = 2;
  localparam int MAXB = 4;

  logic                cpu_clk = 1'b0;
  logic                reset   = 1'b1;
  logic                enable  = 1'b1;
  logic [NSRC-1:0]     src_valid = '0;
  logic [NSRC-1:0]     src_last  = '0;
  logic [NSRC*128-1:0] src_data  = '0;
  logic [NSRC-1:0]     src_ready;
  logic [127:0]        dma_in;
  logic                dma_we;
  logic                dma_writable = 1'b1;
  logic [IDW-1:0]      grant_id;
  logic                busy;
  logic [31:0]         beat_count;

  dma_write_arbiter #(.NSRC(NSRC), .IDW(IDW), .MAX_BURST(MAXB)) dut (
    .cpu_clk(cpu_clk), .reset(reset), .enable(enable),
    .src_valid(src_valid), .src_last(src_last), .src_data(src_data),
    .src_ready(src_ready), .dma_in(dma_in), .dma_we(dma_we),
    .dma_writable(dma_writable), .grant_id(grant_id), .busy(busy),
    .beat_count(beat_count)
  );

  always #5 cpu_clk = ~cpu_clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string name, logic [127:0] got, logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  // Source-side stimulus state
  int  left[NSRC];
  int  seq[NSRC];
  int  reclen[NSRC];
  bit  autold[NSRC];
  bit  nolast[NSRC];
  bit  tog = 1'b0;
  logic [NSRC-1:0] acc_s = '0;

  // Logs of grants (with beat counts) and of written beats
  int           glog[$];
  int           gcnt[$];
  logic [127:0] plog[$];
  int           sb_next[NSRC];
  logic         busy_q = 1'b0;

  // Behavioural model: -1 means no source holds the port
  bit           m_ok = 1'b0;
  int           m_g = -1, m_gid = 0, m_rr = 0, m_n = 0;
  logic         m_we = 1'b0;
  logic [127:0] m_in = '0;
  logic [31:0]  m_cnt = '0;

  always @(negedge cpu_clk) begin
    logic [NSRC-1:0] exp_rdy;
    int s;
    bit acc, fnd;
    if (m_ok) begin
      exp_rdy = '0;
      if (m_g >= 0 && !reset) exp_rdy[m_g] = dma_writable;
      chk("dma_we", dma_we, m_we);
      chk("dma_in", dma_in, m_in);
      chk("busy", busy, m_g >= 0);
      chk("grant_id", grant_id, m_gid);
      chk("beat_count", beat_count, m_cnt);
      chk("src_ready", src_ready, exp_rdy);
      if (dma_we === 1'b1) begin
        plog.push_back(dma_in);
        if (gcnt.size() > 0) gcnt[gcnt.size()-1] += 1;
        s = int'(dma_in[127:120]);
        chk("sb_src_range", s < NSRC, 1'b1);
        if (s < NSRC) begin
          chk("sb_seq", dma_in[31:0], sb_next[s]);
          sb_next[s] = int'(dma_in[31:0]) + 1;
        end
      end
      if (busy === 1'b1 && busy_q !== 1'b1) begin
        glog.push_back(int'(grant_id));
        gcnt.push_back(0);
      end
    end
    busy_q = busy;
    acc_s  = src_valid & src_ready;
    // advance the model across the coming edge
    if (reset) begin
      m_ok = 1'b1; m_g = -1; m_gid = 0; m_rr = 0; m_n = 0;
      m_we = 1'b0; m_in = '0; m_cnt = '0;
      for (int i = 0; i < NSRC; i++) sb_next[i] = 1;
    end else if (m_g < 0) begin
      m_we = 1'b0;
      fnd  = 1'b0;
      if (enable)
        for (int k = 0; k < NSRC; k++)
          if (!fnd && src_valid[(m_rr + k) % NSRC]) begin
            fnd = 1'b1; m_g = (m_rr + k) % NSRC; m_gid = m_g; m_n = 0;
          end
    end else begin
      acc  = src_valid[m_g] && dma_writable;
      m_we = acc;
      if (acc) begin
        m_in  = src_data[m_g*128 +: 128];
        m_cnt = m_cnt + 32'd1;
        m_n++;
        if (src_last[m_g] || m_n == MAXB) begin
          m_rr = (m_g + 1) % NSRC;
          m_g  = -1;
        end
      end
    end
  end

  // pw==200 alternates dma_writable every cycle
  task automatic cycle(input int pv, input int pw);
    @(posedge cpu_clk); #1;
    for (int i = 0; i < NSRC; i++) begin
      if (acc_s[i]) begin
        seq[i]++;
        if (left[i] > 0) left[i]--;
      end
      if (reset) begin seq[i] = 1; left[i] = 0; end
      if (autold[i] && left[i] == 0) left[i] = reclen[i];
      src_valid[i] = (left[i] > 0) && ($urandom_range(99) < pv);
      src_last[i]  = (left[i] == 1) && !nolast[i];
      src_data[i*128 +: 128] = {8'(i), 24'h0, 32'($urandom), 32'($urandom), 32'(seq[i])};
    end
    tog = ~tog;
    dma_writable = (pw == 200) ? tog : ($urandom_range(99) < pw);
  endtask

  task automatic run(input int n, input int pv, input int pw);
    for (int c = 0; c < n; c++) cycle(pv, pw);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < NSRC; i++) begin
      left[i] = 0; autold[i] = 1'b0; nolast[i] = 1'b0; reclen[i] = 1;
    end
    run(2, 100, 100);
    reset = 1'b0;
    enable = 1'b1;
    glog.delete(); gcnt.delete(); plog.delete();
  endtask

  function automatic int qget(input int q[$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  initial begin
    int waited;
    for (int i = 0; i < NSRC; i++) seq[i] = 1;

    // Single source, three-beat record, then round-robin pointer advance
    do_reset();
    chk("reset_beat_count", beat_count, 32'd0);
    chk("reset_grant_id", grant_id, 2'd0);
    left[0] = 3;
    run(10, 100, 100);
    chk("t1_beat_count", beat_count, 32'd3);
    chk("t1_busy", busy, 1'b0);
    chk("t1_pulses", plog.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk("t1_seq", (k < plog.size()) ? plog[k][31:0] : 32'hffffffff, k + 1);
      chk("t1_src", (k < plog.size()) ? plog[k][127:120] : 8'hff, 8'd0);
    end
    left[0] = 1; left[1] = 1;
    run(10, 100, 100);
    chk("t1_rr_first", qget(glog, 1), 1);
    chk("t1_rr_second", qget(glog, 2), 0);

    // All sources with continuous two-beat records
    do_reset();
    for (int i = 0; i < NSRC; i++) begin autold[i] = 1'b1; reclen[i] = 2; end
    run(20, 100, 100);
    for (int i = 0; i < NSRC; i++) autold[i] = 1'b0;
    for (int k = 0; k < 5; k++) chk("t2_order", qget(glog, k), k % NSRC);
    for (int k = 0; k < 4; k++) chk("t2_beats", qget(gcnt, k), 2);

    // Long record without last is split at the burst limit
    do_reset();
    left[2] = 10; nolast[2] = 1'b1; left[3] = 1;
    run(30, 100, 100);
    chk("t3_grants", glog.size(), 4);
    chk("t3_g0", qget(glog, 0), 2); chk("t3_n0", qget(gcnt, 0), 4);
    chk("t3_g1", qget(glog, 1), 3); chk("t3_n1", qget(gcnt, 1), 1);
    chk("t3_g2", qget(glog, 2), 2); chk("t3_n2", qget(gcnt, 2), 4);
    chk("t3_g3", qget(glog, 3), 2); chk("t3_n3", qget(gcnt, 3), 2);

    // Write port alternating availability
    do_reset();
    left[0] = 4;
    run(16, 100, 200);
    chk("t4_pulses", plog.size(), 4);
    for (int k = 0; k < 4; k++)
      chk("t4_seq", (k < plog.size()) ? plog[k][31:0] : 32'hffffffff, k + 1);
    chk("t4_grants", glog.size(), 1);

    // enable gating
    do_reset();
    enable = 1'b0;
    left[1] = 3; left[2] = 3;
    run(10, 100, 100);
    chk("t5_no_grant", glog.size(), 0);
    chk("t5_no_beats", beat_count, 32'd0);
    enable = 1'b1;
    waited = 0;
    while (busy !== 1'b1 && waited < 10) begin cycle(100, 100); waited++; end
    chk("t5_grant_timeout", busy, 1'b1);
    enable = 1'b0;
    run(12, 100, 100);
    chk("t5_grants", glog.size(), 1);
    chk("t5_grant_src", qget(glog, 0), 1);
    chk("t5_pulses", plog.size(), 3);

    // Reset in the middle of a five-beat burst
    do_reset();
    left[0] = 5;
    waited = 0;
    while (plog.size() < 1 && waited < 20) begin cycle(100, 100); waited++; end
    chk("t6_first_beat_timeout", plog.size(), 1);
    reset = 1'b1;
    @(negedge cpu_clk);
    chk("t6_ready_in_reset", src_ready, 4'b0);
    @(negedge cpu_clk);
    chk("t6_we", dma_we, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_count", beat_count, 32'd0);
    chk("t6_ready", src_ready, 4'b0);
    do_reset();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NSRC; i++)
        if (left[i] == 0 && $urandom_range(9) == 0) begin
          left[i]   = $urandom_range(6, 1);
          nolast[i] = ($urandom_range(9) == 0);
        end
      enable = ($urandom_range(9) != 0);
      reset  = ($urandom_range(399) == 0);
      cycle(80, 75);
    end
    reset = 1'b0;
    run(3, 100, 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dma_write_arbiter.md
Name: dma_write_arbiter

Overview:
- Round-robin arbiter that shares the single 128-bit DMA write port (dma_in / dma_we / dma_writable) of the DMA FIFO controller among NSRC trace/data sources.
- Runs entirely in the cpu_clk (FIFO write-side) domain and sits between the sources and the controller's write interface.
- Grants whole bursts, terminated by src_last or by MAX_BURST, so one source's records are never interleaved with another's inside a burst.
- Registers the outgoing write and counts accepted beats for status/LED use.

Parameters:
- NSRC, 4, number of requesting sources (2..8).
- IDW, 2, width of grant_id; must satisfy 2^IDW >= NSRC.
- MAX_BURST, 256, maximum beats per grant before forced re-arbitration (1..65535).

Ports:
- cpu_clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  allows new grants; low does not abort the current burst.
- src_valid  in  NSRC  per-source beat valid.
- src_last  in  NSRC  per-source last beat of the record; qualified by valid.
- src_data  in  NSRC*128  source i data on bits [i*128+127 : i*128].
- src_ready  out  NSRC  per-source accept; combinational.
- dma_in  out  128  write data to the DMA FIFO controller; registered.
- dma_we  out  1  write strobe, one cycle per beat; registered.
- dma_writable  in  1  controller can take a write this cycle.
- grant_id  out  IDW  index of the currently granted source; registered.
- busy  out  1  high while in BURST state.
- beat_count  out  32  total accepted beats since reset.

Behaviour:
- Reset values (applied on a cpu_clk edge with reset=1):
  - state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0.
  - dma_we=0, dma_in=0, busy=0, beat_count=0.
  - src_ready is all zeros while reset is high and in the cycle after it.
- Reset mid-burst: abandons the burst at that edge. No dma_we after that edge. The source must restart its record.
- States:
  - IDLE: src_ready=0. If enable=1 and any src_valid bit is 1, select the first valid source searching upward from rr_ptr with wrap-around (rr_ptr, rr_ptr+1, ..., NSRC-1, 0, ...). Register grant_id=selected, burst_cnt=0, go to BURST. Otherwise stay in IDLE.
  - BURST: src_ready[grant_id]=dma_writable; all other src_ready bits are 0.
    - accept = src_valid[grant_id] & src_ready[grant_id].
    - On accept, at the next edge: dma_in=src_data of the granted source, dma_we=1, beat_count+1, burst_cnt+1.
    - Without accept, at the next edge: dma_we=0 and dma_in holds its value.
  - BURST exit: on accept with src_last[grant_id]=1, or on accept when burst_cnt=MAX_BURST-1. Next state is IDLE and rr_ptr=(grant_id+1) mod NSRC.
  - If the granted source drops src_valid mid-burst, the grant is held indefinitely (no timeout). Other sources wait.
- Latency: source valid in IDLE at edge t -> grant at t+1 -> first accept possible in cycle t+1 -> dma_we high after edge t+2.
  - Minimum of one idle cycle (IDLE state) between bursts.
  - Sustained burst throughput is 1 beat/cycle while dma_writable=1.
- dma_writable low: no beat is accepted and src_ready is 0 that cycle. Data is never dropped or duplicated; every accepted beat produces exactly one dma_we pulse.
- enable low in IDLE: no grant, even with valid sources. enable low in BURST: the burst runs to completion.
- beat_count wraps from 0xFFFFFFFF to 0. burst_cnt never exceeds MAX_BURST-1.
- busy = (state==BURST). grant_id is stable for the whole burst.
- src_data and src_last of non-granted sources are ignored.

Test Plan:
- Reset, then only source 0 sends 3 beats (data 0x..01..03, last on the 3rd) with dma_writable=1 -> dma_we high for 3 consecutive cycles with matching dma_in, beat_count=3, busy back to 0, rr_ptr=1.
- All 4 sources valid continuously, each record 2 beats -> grant order 0,1,2,3,0; no interleaving within any record; 2 dma_we pulses per grant with one idle cycle between grants.
- MAX_BURST=4, source 2 streams 10 beats with no last -> grants of 4, 4, 2 beats; when another source is valid, it is granted between them.
- dma_writable toggles 1,0,1,0 during a 4-beat burst -> src_ready mirrors dma_writable; exactly 4 dma_we pulses, in order, with no duplicates.
- enable=0 with sources valid -> no grant, dma_we=0. enable dropped mid-burst -> the burst completes, then no new grant.
- reset asserted on the 2nd beat of a 5-beat burst -> dma_we=0 from the next edge, state IDLE, beat_count=0, all src_ready 0.
